arbiter_iwrr_1cycle: RTL and testbench
======================================

ARBITER_IWRR_1CYCLE -- requirements
Module: arbiter_iwrr_1cycle

Interface
REQ-001 Parameter P_REQUESTER_NUM, default 3: number of requesters N; N SHALL be >= 2.
REQ-002 Parameter P_REQUESTER_WEIGHT [0:N*32-1], default {32'd5, 32'd3, 32'd2}: weight of requester i in bits [i*32 +: 32]; every weight SHALL be >= 1 and weight[0] SHALL be the maximum (Wmax).
REQ-003 Derived localparam P_WEIGHT_W = $clog2(weight[0]), floored at 1; default 3.
REQ-004 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_i  input  N  request bit per requester; bit i = requester i.
REQ-008 num_grant_req_i  input  P_WEIGHT_W  grant quantum: accepted handshakes per slot; 0 is treated as 1.
REQ-009 grant_ready_i  input  1  consumer accepts the current grant.
REQ-010 grant_valid_o  output  N  one-hot grant, or all-zero when idle.

Function
REQ-011 State SHALL be: round r (1..Wmax), pointer p (0..N-1), and quantum counter cnt; the internal width of r SHALL hold Wmax.
REQ-012 Pair (k, j) SHALL be eligible iff req_i[j]=1 and weight[j] >= k.
REQ-013 Scan order SHALL start at (r, p), increment j to N-1, then move to (next round, j=0); round Wmax wraps to round 1; one full cycle covers Wmax*N pairs.
REQ-014 grant_valid_o SHALL be combinational, same cycle as req_i: one-hot at the first eligible pair (k*, j*) in scan order, and zero if req_i == 0.
REQ-015 grant_valid_o SHALL NOT depend on grant_ready_i.
REQ-016 A handshake SHALL occur on a rising clk edge where grant_ready_i=1 and grant_valid_o != 0.
REQ-017 On a handshake with cnt+1 < max(num_grant_req_i,1): cnt SHALL increment and r and p SHALL hold.
REQ-018 Otherwise, on a handshake: cnt SHALL clear; p SHALL become j*+1 and r SHALL become k*; if j*+1 = N, p SHALL become 0 and r SHALL become k*+1, wrapping from Wmax to 1.
REQ-019 Without a handshake (ready low or no request), r, p and cnt SHALL hold; grant_valid_o may change if req_i changes.
REQ-020 Requests SHALL be level-sensitive; a dropped request is skipped and the scan proceeds from the held state.
REQ-021 With all requesting and quantum 1, each full cycle SHALL grant requester i exactly weight[i] times, interleaved: default sequence 0,1,2,0,1,2,0,1,0,0 repeating.
REQ-022 One grant per cycle at most; sustained throughput SHALL be one handshake per clk.

Reset
REQ-023 rst_n low SHALL asynchronously set r=1, p=0, cnt=0.
REQ-024 grant_valid_o SHALL be forced to 0 while rst_n is low.
REQ-025 After reset release, the first grant SHALL be the lowest-index eligible requester in round 1.
REQ-026 Reset asserted mid-sequence SHALL discard all progress; there SHALL be no partial-cycle carry-over.

Verification
REQ-027 Defaults, req_i=3'b111, ready=1, quantum=1 after reset -> grant_valid_o per cycle: 001,010,100,001,010,100,001,010,001,001, then repeat.
REQ-028 req_i=3'b001, ready=1 -> grant_valid_o=001 every cycle, and r advances 1..5 cyclically.
REQ-029 req_i=3'b011, ready=1, starting from reset state -> 001,010,001,010,001,010,001,001, then repeat.
REQ-030 grant_ready_i=0 with req_i=3'b011 -> grant_valid_o holds the same one-hot value indefinitely and the state is frozen; ready=1 resumes the sequence exactly where it stopped.
REQ-031 num_grant_req_i=2, req_i=3'b111, ready=1 -> each grant is held for 2 cycles: 001,001,010,010,100,100,...
REQ-032 rst_n pulsed low mid-sequence -> grant_valid_o=000 during reset, then restart at 001.

Source files
------------

// File: rtl/arbiter_iwrr_1cycle.sv
// Interleaved weighted round-robin arbiter with a same-cycle combinational grant.
// Scans (round, requester) pairs from the held (r, p) position and grants the first eligible one.
module arbiter_iwrr_1cycle #(
    parameter int P_REQUESTER_NUM = 3,
    parameter logic [0:P_REQUESTER_NUM*32-1] P_REQUESTER_WEIGHT = {32'd5, 32'd3, 32'd2},
    localparam int WMAX = int'(P_REQUESTER_WEIGHT[0:31]),
    localparam int P_WEIGHT_W = ($clog2(WMAX) < 1) ? 1 : $clog2(WMAX)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [P_REQUESTER_NUM-1:0] req_i,
    input  logic [P_WEIGHT_W-1:0]      num_grant_req_i,
    input  logic                       grant_ready_i,
    output logic [P_REQUESTER_NUM-1:0] grant_valid_o
);

    localparam int N     = P_REQUESTER_NUM;
    localparam int T     = WMAX * N;
    localparam int IDX_W = $clog2(T);
    localparam int R_W   = $clog2(WMAX + 1);
    localparam int P_W   = $clog2(N);

    function automatic int weight_of(input int i);
        return int'(P_REQUESTER_WEIGHT[i*32 +: 32]);
    endfunction

    logic [R_W-1:0]        r_reg, r_next;
    logic [P_W-1:0]        p_reg, p_next;
    logic [P_WEIGHT_W-1:0] cnt_reg, cnt_next;

    logic [T-1:0]          elig;
    logic [R_W-1:0]        k_tab [T];
    logic [P_W-1:0]        j_tab [T];

    logic                  found;
    logic [IDX_W-1:0]      sel_idx;
    logic [R_W-1:0]        sel_k;
    logic [P_W-1:0]        sel_j;
    logic                  handshake;
    logic [P_WEIGHT_W-1:0] quantum;
    logic [P_WEIGHT_W:0]   cnt_inc;

    // Linear pair index gi = (k-1)*N + j; round and requester come from constant tables.
    genvar gi;
    generate
        for (gi = 0; gi < T; gi++) begin : g_pair
            localparam int  K    = gi / N + 1;
            localparam int  J    = gi % N;
            localparam bit  W_OK = (weight_of(J) >= K);
            assign elig[gi]  = W_OK && req_i[J];
            assign k_tab[gi] = R_W'(K);
            assign j_tab[gi] = P_W'(J);
        end
    endgenerate

    always_comb begin
        int start_idx;
        int l;
        found     = 1'b0;
        sel_idx   = '0;
        start_idx = (int'(r_reg) - 1) * N + int'(p_reg);
        l         = 0;
        for (int o = 0; o < T; o++) begin
            l = start_idx + o;
            if (l >= T) l = l - T;
            if (!found && elig[l[IDX_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = l[IDX_W-1:0];
            end
        end
    end

    assign sel_k         = k_tab[sel_idx];
    assign sel_j         = j_tab[sel_idx];
    assign grant_valid_o = (found && rst_n) ? ({{(N-1){1'b0}}, 1'b1} << sel_j) : '0;

    assign handshake = grant_ready_i && found;
    assign quantum   = (num_grant_req_i == '0) ? P_WEIGHT_W'(1) : num_grant_req_i;
    assign cnt_inc   = {1'b0, cnt_reg} + {{P_WEIGHT_W{1'b0}}, 1'b1};

    always_comb begin
        r_next   = r_reg;
        p_next   = p_reg;
        cnt_next = cnt_reg;
        if (handshake) begin
            if (cnt_inc < {1'b0, quantum}) begin
                cnt_next = cnt_inc[P_WEIGHT_W-1:0];
            end else begin
                cnt_next = '0;
                // Resume just past the granted pair; stepping off the last requester opens the next round.
                if (sel_j == P_W'(N - 1)) begin
                    p_next = '0;
                    r_next = (sel_k == R_W'(WMAX)) ? R_W'(1) : sel_k + R_W'(1);
                end else begin
                    p_next = sel_j + P_W'(1);
                    r_next = sel_k;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg   <= R_W'(1);
            p_reg   <= '0;
            cnt_reg <= '0;
        end else begin
            r_reg   <= r_next;
            p_reg   <= p_next;
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: tb/tb_arbiter_iwrr_1cycle.sv
// Directed bench: stimulus pushes expected per-cycle grants into a queue, a monitor pops and compares.
module tb_arbiter_iwrr_1cycle;

    logic       clk;
    logic       rst_n;
    logic [2:0] req_i;
    logic [2:0] num_grant_req_i;
    logic       grant_ready_i;
    logic [2:0] grant_valid_o;

    logic [2:0] exp_q[$];
    logic [2:0] seq[$];
    int         n_vec;
    int         n_miss;

    arbiter_iwrr_1cycle dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_i           (req_i),
        .num_grant_req_i (num_grant_req_i),
        .grant_ready_i   (grant_ready_i),
        .grant_valid_o   (grant_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one comparison per pending expectation, sampled on the falling edge.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (grant_valid_o !== e) begin
                    n_miss++;
                    $display("FAIL grant vec %0d: got %b expected %b (req=%b rdy=%b q=%0d rst_n=%b)",
                             n_vec, grant_valid_o, e, req_i, grant_ready_i, num_grant_req_i, rst_n);
                end else begin
                    $display("vec %0d ok: grant=%b req=%b rdy=%b q=%0d rst_n=%b",
                             n_vec, grant_valid_o, req_i, grant_ready_i, num_grant_req_i, rst_n);
                end
            end
        end
    end

    task automatic step(input logic [2:0] req, input logic rdy, input logic [2:0] q, input logic [2:0] exp);
        @(posedge clk);
        #1;
        rst_n           = 1'b1;
        req_i           = req;
        grant_ready_i   = rdy;
        num_grant_req_i = q;
        exp_q.push_back(exp);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.push_back(3'b000);
    endtask

    task automatic run(input logic [2:0] req, input logic rdy, input logic [2:0] q);
        foreach (seq[i]) step(req, rdy, q, seq[i]);
    endtask

    initial begin
        n_vec           = 0;
        n_miss          = 0;
        rst_n           = 1'b0;
        req_i           = 3'b111;
        grant_ready_i   = 1'b1;
        num_grant_req_i = 3'd1;

        // Reset state, then the default interleaved sequence with a wrap into the next cycle
        do_reset();
        do_reset();
        seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b001, 3'b001,
                3'b001, 3'b010, 3'b100};
        run(3'b111, 1'b1, 3'd1);

        // Mid-sequence reset discards progress
        seq = '{3'b001, 3'b010};
        run(3'b111, 1'b1, 3'd1);
        do_reset();
        seq = '{3'b001, 3'b010, 3'b100};
        run(3'b111, 1'b1, 3'd1);

        // Two requesters: 0,1,0,1,0,1,0,0 repeating
        do_reset();
        seq = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010};
        run(3'b011, 1'b1, 3'd1);

        // Ready low freezes state and grant; resuming continues the same sequence
        do_reset();
        seq = '{3'b001, 3'b010, 3'b001};
        run(3'b011, 1'b1, 3'd1);
        seq = '{3'b010, 3'b010, 3'b010, 3'b010};
        run(3'b011, 1'b0, 3'd1);
        seq = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010};
        run(3'b011, 1'b1, 3'd1);

        // Quantum of 2 holds each grant for two handshakes
        do_reset();
        seq = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
        run(3'b111, 1'b1, 3'd2);

        // Quantum 0 behaves as 1
        do_reset();
        seq = '{3'b001, 3'b010, 3'b100, 3'b001};
        run(3'b111, 1'b1, 3'd0);

        // Lone requester 0 walks the round; switching to all reveals r=3, p=1
        do_reset();
        seq = '{3'b001, 3'b001, 3'b001};
        run(3'b001, 1'b1, 3'd1);
        seq = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
        run(3'b111, 1'b1, 3'd1);

        // No request: grant idle and state held
        do_reset();
        step(3'b111, 1'b1, 3'd1, 3'b001);
        seq = '{3'b000, 3'b000};
        run(3'b000, 1'b1, 3'd1);
        seq = '{3'b010, 3'b100};
        run(3'b111, 1'b1, 3'd1);

        // Dropped request is skipped from the held position
        do_reset();
        step(3'b111, 1'b1, 3'd1, 3'b001);
        step(3'b101, 1'b1, 3'd1, 3'b100);
        seq = '{3'b001, 3'b010};
        run(3'b111, 1'b1, 3'd1);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
